// File: rtl/teng_pkt_gen_chk.sv
// teng_pkt_gen_chk: AXIS packet generator and loopback checker for 10G MAC bring-up.
// Byte k of packet p carries (p + k) mod 256. The generator and the checker each run
// their own copy of the length sequencer, so the checker never depends on tx state.
module teng_pkt_gen_chk #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 32,
    parameter int IPG_BEATS = 2
) (
    input  logic                         user_clk_i,
    input  logic                         user_rst_i,
    input  logic                         start_i,
    input  logic                         stop_i,
    input  logic [CNT_W-1:0]             num_pkts_i,
    input  logic                         len_mode_i,
    input  logic [15:0]                  len_min_i,
    input  logic [15:0]                  len_max_i,
    output logic [DATA_W-1:0]            tx_data_o,
    output logic [$clog2(DATA_W/8):0]    tx_vldb_o,
    output logic                         tx_valid_o,
    input  logic                         tx_ready_i,
    output logic                         tx_last_o,
    output logic                         tx_user_o,
    input  logic [DATA_W-1:0]            rx_data_i,
    input  logic [$clog2(DATA_W/8):0]    rx_vldb_i,
    input  logic                         rx_valid_i,
    input  logic                         rx_last_i,
    input  logic                         rx_user_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic [CNT_W-1:0]             tx_pkt_cnt_o,
    output logic [CNT_W-1:0]             rx_pkt_cnt_o,
    output logic [CNT_W-1:0]             len_err_cnt_o,
    output logic [CNT_W-1:0]             data_err_cnt_o,
    output logic [CNT_W-1:0]             crc_err_cnt_o
);
    localparam int NB     = DATA_W / 8;
    localparam int VLDB_W = $clog2(NB) + 1;
    localparam int GAP_W  = (IPG_BEATS > 1) ? $clog2(IPG_BEATS) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP, DRAIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [VLDB_W-1:0] vldb;
        logic              last;
    } beat_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Incrementing mode wraps max -> min; an inverted range degenerates to fixed length.
    function automatic logic [15:0] next_len(input logic [15:0] cur, input logic mode,
                                             input logic [15:0] lmin, input logic [15:0] lmax);
        if (mode && (lmax >= lmin) && (cur < lmax)) return cur + 16'd1;
        return lmin;
    endfunction

    // Builds the beat starting at byte offset off; bytes past the packet end are zero.
    function automatic beat_t make_beat(input logic [7:0] p, input logic [15:0] off,
                                        input logic [15:0] len);
        beat_t       b;
        logic [16:0] k;
        logic [15:0] rem;
        b.data = '0;
        for (int i = 0; i < NB; i++) begin
            k = {1'b0, off} + 17'(i);
            if (k < {1'b0, len}) b.data[8*i +: 8] = p + k[7:0];
        end
        rem    = len - off;
        b.vldb = (rem >= 16'(NB)) ? VLDB_W'(NB) : rem[VLDB_W-1:0];
        b.last = (rem <= 16'(NB));
        return b;
    endfunction

    // True when any valid byte that lies inside the expected length is wrong.
    function automatic logic mismatch(input logic [DATA_W-1:0] d, input logic [VLDB_W-1:0] vldb,
                                      input logic [7:0] p, input logic [16:0] off,
                                      input logic [15:0] len);
        logic        m;
        logic [16:0] k;
        m = 1'b0;
        for (int i = 0; i < NB; i++) begin
            k = off + 17'(i);
            if ((VLDB_W'(i) < vldb) && (k < {1'b0, len}) && (d[8*i +: 8] != p + k[7:0])) m = 1'b1;
        end
        return m;
    endfunction

    state_t             state;
    logic [CNT_W-1:0]   num_pkts;
    logic               mode;
    logic [15:0]        lmin;
    logic [15:0]        lmax;
    logic               stop_req;
    logic [7:0]         tx_p;
    logic [15:0]        tx_off;
    logic [15:0]        tx_len;
    logic [GAP_W-1:0]   gap_cnt;

    logic [7:0]         rx_p;
    logic [16:0]        rx_off;
    logic [15:0]        rx_len;
    logic               rx_bad;

    logic               start_ok;
    logic [15:0]        lmin_eff;
    logic [15:0]        tx_len_nx;
    logic [CNT_W-1:0]   tx_cnt_nx;
    logic [CNT_W-1:0]   rx_cnt_nx;
    logic               end_run;
    logic               rx_mis;
    logic [17:0]        rx_sum;
    logic [16:0]        rx_total;

    assign tx_user_o = 1'b0;
    assign start_ok  = start_i && (state == IDLE);
    assign lmin_eff  = (len_min_i == 16'd0) ? 16'd1 : len_min_i;
    assign tx_len_nx = next_len(tx_len, mode, lmin, lmax);
    assign tx_cnt_nx = sat_inc(tx_pkt_cnt_o);
    assign rx_cnt_nx = (rx_valid_i && rx_last_i) ? sat_inc(rx_pkt_cnt_o) : rx_pkt_cnt_o;
    assign end_run   = ((num_pkts != '0) && (tx_cnt_nx == num_pkts)) || stop_req || stop_i;
    assign rx_mis    = mismatch(rx_data_i, rx_vldb_i, rx_p, rx_off, rx_len);
    assign rx_sum    = {1'b0, rx_off} + 18'(rx_vldb_i);
    assign rx_total  = rx_sum[17] ? '1 : rx_sum[16:0];

    // Generator FSM: run control, tx beat sequencing and the tx packet counter.
    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            num_pkts     <= '0;
            mode         <= 1'b0;
            lmin         <= '0;
            lmax         <= '0;
            stop_req     <= 1'b0;
            tx_p         <= '0;
            tx_off       <= '0;
            tx_len       <= '0;
            gap_cnt      <= '0;
            tx_pkt_cnt_o <= '0;
            {tx_valid_o, tx_data_o, tx_vldb_o, tx_last_o} <= '0;
        end else begin
            if (stop_i && (state != IDLE)) stop_req <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state        <= SEND;
                        busy_o       <= 1'b1;
                        done_o       <= 1'b0;
                        num_pkts     <= num_pkts_i;
                        mode         <= len_mode_i;
                        lmin         <= lmin_eff;
                        lmax         <= len_max_i;
                        stop_req     <= 1'b0;
                        tx_p         <= '0;
                        tx_off       <= '0;
                        tx_len       <= lmin_eff;
                        tx_pkt_cnt_o <= '0;
                        tx_valid_o   <= 1'b1;
                        {tx_data_o, tx_vldb_o, tx_last_o} <= make_beat(8'd0, 16'd0, lmin_eff);
                    end
                end
                SEND: begin
                    if (tx_valid_o && tx_ready_i) begin
                        if (!tx_last_o) begin
                            tx_off <= tx_off + 16'(NB);
                            {tx_data_o, tx_vldb_o, tx_last_o} <= make_beat(tx_p, tx_off + 16'(NB), tx_len);
                        end else begin
                            tx_pkt_cnt_o <= tx_cnt_nx;
                            tx_p         <= tx_p + 8'd1;
                            tx_len       <= tx_len_nx;
                            tx_off       <= '0;
                            gap_cnt      <= '0;
                            if (end_run) begin
                                {tx_valid_o, tx_data_o, tx_vldb_o, tx_last_o} <= '0;
                                // A zero-latency loopback may already have delivered the last packet.
                                if (rx_cnt_nx == tx_cnt_nx) begin
                                    state  <= IDLE;
                                    busy_o <= 1'b0;
                                    done_o <= 1'b1;
                                end else begin
                                    state <= DRAIN;
                                end
                            end else if (IPG_BEATS == 0) begin
                                {tx_data_o, tx_vldb_o, tx_last_o} <= make_beat(tx_p + 8'd1, 16'd0, tx_len_nx);
                            end else begin
                                state <= GAP;
                                {tx_valid_o, tx_data_o, tx_vldb_o, tx_last_o} <= '0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (stop_req || stop_i) begin
                        state <= DRAIN;
                    end else if (gap_cnt == GAP_W'(IPG_BEATS - 1)) begin
                        state      <= SEND;
                        tx_valid_o <= 1'b1;
                        {tx_data_o, tx_vldb_o, tx_last_o} <= make_beat(tx_p, 16'd0, tx_len);
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                DRAIN: begin
                    if (rx_cnt_nx == tx_pkt_cnt_o) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Checker: independent length sequencer plus per-packet length, data and CRC scoring.
    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            rx_p           <= '0;
            rx_off         <= '0;
            rx_len         <= '0;
            rx_bad         <= 1'b0;
            rx_pkt_cnt_o   <= '0;
            len_err_cnt_o  <= '0;
            data_err_cnt_o <= '0;
            crc_err_cnt_o  <= '0;
        end else if (start_ok) begin
            rx_p           <= '0;
            rx_off         <= '0;
            rx_len         <= lmin_eff;
            rx_bad         <= 1'b0;
            rx_pkt_cnt_o   <= '0;
            len_err_cnt_o  <= '0;
            data_err_cnt_o <= '0;
            crc_err_cnt_o  <= '0;
        end else if (rx_valid_i) begin
            if (rx_last_i) begin
                rx_pkt_cnt_o <= sat_inc(rx_pkt_cnt_o);
                if (rx_bad || rx_mis)            data_err_cnt_o <= sat_inc(data_err_cnt_o);
                if (rx_total != {1'b0, rx_len}) len_err_cnt_o  <= sat_inc(len_err_cnt_o);
                if (rx_user_i)                  crc_err_cnt_o  <= sat_inc(crc_err_cnt_o);
                rx_p   <= rx_p + 8'd1;
                rx_off <= '0;
                rx_bad <= 1'b0;
                rx_len <= next_len(rx_len, mode, lmin, lmax);
            end else begin
                rx_off <= rx_total;
                rx_bad <= rx_bad | rx_mis;
            end
        end
    end

endmodule

// File: tb/tb_teng_pkt_gen_chk.sv
// tb_teng_pkt_gen_chk: loops tx back to rx with optional fault injection and
// runs a table of directed runs plus hand-written control sequences.
module tb_teng_pkt_gen_chk;
    localparam int DW  = 64;
    localparam int CW  = 16;
    localparam int IPG = 3;
    localparam logic [DW-1:0] FLIP = 64'h0000_0100_0000_0000; // bit 0 of byte 5

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [CW-1:0] num_pkts = '0;
    logic          len_mode = 1'b0;
    logic [15:0]   len_min = '0;
    logic [15:0]   len_max = '0;
    logic [DW-1:0] tx_data;
    logic [3:0]    tx_vldb;
    logic          tx_valid;
    logic          tx_ready = 1'b1;
    logic          tx_last;
    logic          tx_user;
    logic [DW-1:0] rx_data;
    logic [3:0]    rx_vldb;
    logic          rx_valid;
    logic          rx_last;
    logic          rx_user;
    logic          busy;
    logic          done;
    logic [CW-1:0] tx_cnt, rx_cnt, len_err, data_err, crc_err;

    int checks = 0;
    int errors = 0;

    // fault: 0 none, 1 data bit flip in pkt 2, 2 CRC flag on pkt 6, 3 drop last beat of pkt 4
    int fault = 0;
    int base_pkt = 0;

    // monitor state (written only by the monitor process)
    int mon_pkt = 0, mon_beat = 0, mon_beats = 0, mon_vsum = 0;
    int fpkt = 0, fbeat = 0;
    int mon_gaps = 0, mon_gap_bad = 0, mon_stall_bad = 0;
    int idle = 0;
    bit gap_arm = 0, stall = 0;
    logic [DW+5:0] saved;

    teng_pkt_gen_chk #(.DATA_W(DW), .CNT_W(CW), .IPG_BEATS(IPG)) dut (
        .user_clk_i(clk), .user_rst_i(rst), .start_i(start), .stop_i(stop),
        .num_pkts_i(num_pkts), .len_mode_i(len_mode), .len_min_i(len_min), .len_max_i(len_max),
        .tx_data_o(tx_data), .tx_vldb_o(tx_vldb), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .tx_last_o(tx_last), .tx_user_o(tx_user),
        .rx_data_i(rx_data), .rx_vldb_i(rx_vldb), .rx_valid_i(rx_valid), .rx_last_i(rx_last),
        .rx_user_i(rx_user), .busy_o(busy), .done_o(done),
        .tx_pkt_cnt_o(tx_cnt), .rx_pkt_cnt_o(rx_cnt), .len_err_cnt_o(len_err),
        .data_err_cnt_o(data_err), .crc_err_cnt_o(crc_err)
    );

    always #5 clk = ~clk;

    // loopback path with fault injection keyed on the beat being accepted
    always_comb begin
        rx_data  = tx_data ^ (((fault == 1) && (fpkt - base_pkt == 2) && (fbeat == 0)) ? FLIP : '0);
        rx_vldb  = tx_vldb;
        rx_last  = tx_last;
        rx_valid = tx_valid & tx_ready & ~((fault == 3) && (fpkt - base_pkt == 4) && tx_last);
        rx_user  = (fault == 2) && (fpkt - base_pkt == 6) && tx_last;
    end

    // tx monitor: beat accounting, stall stability and inter-packet gap length
    always @(negedge clk) begin
        if (rst) begin
            mon_beat = 0;
            gap_arm  = 0;
            stall    = 0;
        end else begin
            if (stall && ({tx_valid, tx_data, tx_vldb, tx_last} != saved)) mon_stall_bad++;
            if (!busy) gap_arm = 0;
            else if (gap_arm) begin
                if (tx_valid) begin
                    mon_gaps++;
                    if (idle != IPG) mon_gap_bad++;
                    gap_arm = 0;
                end else idle++;
            end
            fpkt  = mon_pkt;
            fbeat = mon_beat;
            if (tx_valid && tx_ready) begin
                mon_beats++;
                if (tx_last) begin
                    mon_vsum += int'(tx_vldb);
                    mon_pkt++;
                    mon_beat = 0;
                    gap_arm  = 1;
                    idle     = 0;
                end else mon_beat++;
            end
            stall = tx_valid && !tx_ready;
            saved = {tx_valid, tx_data, tx_vldb, tx_last};
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int num; bit mode; int lmin; int lmax; int flt; bit bp;
        int tx; int rx; int lerr; int derr; int cerr; int beats; int vsum; int gaps;
    } vec_t;

    vec_t tbl[8];

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_rel(input int pkt, input int beat, input int limit, input string name);
        int n = 0;
        while (!((mon_pkt - base_pkt == pkt) && (mon_beat == beat)) && n < limit) begin
            @(posedge clk); #1; n++;
        end
        chk(name, n < limit, 1);
    endtask

    task automatic run_case(input vec_t v, input int idx);
        int n = 0, b0, v0, g0, s0;
        num_pkts = CW'(v.num); len_mode = v.mode;
        len_min = 16'(v.lmin); len_max = 16'(v.lmax);
        fault = v.flt; tx_ready = 1'b1;
        base_pkt = mon_pkt; b0 = mon_beats; v0 = mon_vsum; g0 = mon_gaps; s0 = mon_stall_bad + mon_gap_bad;
        pulse_start();
        chk($sformatf("c%0d_first_valid", idx), tx_valid, 1);
        chk($sformatf("c%0d_done_cleared", idx), done, 0);
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            tx_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            n++;
        end
        tx_ready = 1'b1;
        chk($sformatf("c%0d_done", idx), done, 1);
        chk($sformatf("c%0d_busy", idx), busy, 0);
        chk($sformatf("c%0d_tx_cnt", idx), tx_cnt, v.tx);
        chk($sformatf("c%0d_rx_cnt", idx), rx_cnt, v.rx);
        chk($sformatf("c%0d_len_err", idx), len_err, v.lerr);
        chk($sformatf("c%0d_data_err", idx), data_err, v.derr);
        chk($sformatf("c%0d_crc_err", idx), crc_err, v.cerr);
        chk($sformatf("c%0d_beats", idx), mon_beats - b0, v.beats);
        chk($sformatf("c%0d_last_vldb_sum", idx), mon_vsum - v0, v.vsum);
        chk($sformatf("c%0d_gaps", idx), mon_gaps - g0, v.gaps);
        chk($sformatf("c%0d_stall_gap_violations", idx), mon_stall_bad + mon_gap_bad - s0, 0);
        fault = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        //            num mode lmin lmax flt bp  tx rx le de ce beats vsum gaps
        tbl[0] = '{ 1, 0, 60, 60, 0, 0,  1, 1, 0, 0, 0,  8,  4,  0};
        tbl[1] = '{ 7, 1, 60, 62, 0, 0,  7, 7, 0, 0, 0, 56, 34,  6};
        tbl[2] = '{ 7, 0, 60, 60, 1, 0,  7, 7, 0, 1, 0, 56, 28,  6};
        tbl[3] = '{ 7, 0, 60, 60, 2, 0,  7, 7, 0, 0, 1, 56, 28,  6};
        tbl[4] = '{ 3, 0,  0,  0, 0, 0,  3, 3, 0, 0, 0,  3,  3,  2};
        tbl[5] = '{ 3, 1, 10,  5, 0, 0,  3, 3, 0, 0, 0,  6,  6,  2};
        tbl[6] = '{ 2, 0, 64, 64, 0, 0,  2, 2, 0, 0, 0, 16, 16,  1};
        tbl[7] = '{20, 1, 20, 30, 0, 1, 20,20, 0, 0, 0, 70, 91, 19};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // reset state
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_tx_vldb", tx_vldb, 0);
        chk("rst_tx_last", tx_last, 0);
        chk("rst_tx_user", tx_user, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_counters", tx_cnt | rx_cnt | len_err | data_err | crc_err, 0);

        // reset mid-packet: everything clears asynchronously
        num_pkts = 5; len_mode = 0; len_min = 60; len_max = 60; fault = 0;
        base_pkt = mon_pkt;
        pulse_start();
        wait_rel(1, 2, 200, "mid_rst_reach");
        rst = 1'b1;
        #1;
        chk("mid_rst_tx_valid", tx_valid, 0);
        chk("mid_rst_tx_data", tx_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_counters", tx_cnt | rx_cnt | len_err | data_err | crc_err, 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_case(tbl[i], i);

        // stop mid-packet in continuous mode, with a start pulse while busy
        num_pkts = 0; len_mode = 0; len_min = 60; len_max = 60; fault = 0;
        base_pkt = mon_pkt;
        pulse_start();
        wait_rel(1, 1, 200, "stop_reach");
        pulse_start();
        chk("busy_start_ignored_cnt", tx_cnt, 1);
        chk("busy_start_ignored_busy", busy, 1);
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        chk("stop_pkt_in_flight", tx_valid, 1);
        begin
            int n = 0;
            while (!done && n < 500) begin @(posedge clk); #1; n++; end
        end
        chk("stop_done", done, 1);
        chk("stop_busy", busy, 0);
        chk("stop_tx_cnt", tx_cnt, 2);
        chk("stop_rx_cnt", rx_cnt, 2);
        chk("stop_errors", len_err | data_err | crc_err, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("stop_stays_idle", tx_valid, 0);
        chk("done_sticky", done, 1);

        // dropped last beat: checker merges packets, drain never completes
        num_pkts = 7; len_mode = 0; len_min = 60; len_max = 60; fault = 3;
        base_pkt = mon_pkt;
        pulse_start();
        wait_rel(7, 0, 500, "drop_reach");
        repeat (10) @(posedge clk);
        #1;
        chk("drop_tx_cnt", tx_cnt, 7);
        chk("drop_rx_cnt", rx_cnt, 6);
        chk("drop_len_err_seen", len_err >= 1, 1);
        chk("drop_not_done", done, 0);
        chk("drop_still_busy", busy, 1);
        rst = 1'b1;
        fault = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("drop_rst_done", done, 0);

        // clean run after reset
        run_case(tbl[0], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
